// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: bundles the ROM address/data pair and the core-side fetch/redirect signals.
//   master (sequencer): drives rom_addr, instr, instr_pc, instr_valid;
//                       samples rom_instr, stall, branch_taken, branch_off, jump, jump_addr.
//   slave (core + ROM): the mirror image of master.
interface fetch_sequencer_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 9
);
  logic               stall;
  logic               branch_taken;
  logic [ADDR_W-1:0]  branch_off;
  logic               jump;
  logic [ADDR_W-1:0]  jump_addr;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_instr;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  modport master (
    input  stall, branch_taken, branch_off, jump, jump_addr, rom_instr,
    output rom_addr, instr, instr_pc, instr_valid
  );
  modport slave (
    output stall, branch_taken, branch_off, jump, jump_addr, rom_instr,
    input  rom_addr, instr, instr_pc, instr_valid
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: program counter sequencer feeding one instruction per cycle from a combinational ROM.
//   clk, reset_n (async, active-low), start      : clock, reset, program (re)start
//   bus (fetch_sequencer_if.master)              : ROM address/data, instruction register, redirects, stall
//   running, halted                              : run/halt status
//   retired_count (only with RETIRE_COUNT_EN)    : saturating count of retired instructions
//   Optional feature macro: RETIRE_COUNT_EN
module fetch_sequencer #(
  parameter int                 ADDR_W      = 8,
  parameter int                 INSTR_W     = 9,
  parameter logic [ADDR_W-1:0]  START_ADDR  = 8'h00,
  parameter logic [INSTR_W-1:0] HALT_OPCODE = 9'b0111_00_010
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  fetch_sequencer_if.master bus,
  output logic running,
  output logic halted
`ifdef RETIRE_COUNT_EN
  ,
  output logic [15:0] retired_count
`endif
);
  typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
  state_t             state, state_d;
  logic [ADDR_W-1:0]  pc, pc_d, ipc_d;
  logic [INSTR_W-1:0] instr_d;
  logic               valid_d;
  assign bus.rom_addr = pc;
  assign running      = state == RUN;
  assign halted       = state == HALTED;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  always_comb begin
    state_d = state;
    pc_d    = pc;
    instr_d = bus.instr;
    ipc_d   = bus.instr_pc;
    valid_d = bus.instr_valid;
    if (state != RUN) begin
      valid_d = 1'b0;
      if (start) begin
        state_d = RUN;
        pc_d    = START_ADDR;
      end
    end else if (!bus.stall) begin
      if (bus.instr_valid && bus.instr == HALT_OPCODE) begin
        // park the ROM address on the halt instruction itself
        state_d = HALTED;
        valid_d = 1'b0;
        pc_d    = bus.instr_pc;
      end else if (bus.instr_valid && (bus.jump || bus.branch_taken)) begin
        pc_d    = bus.jump ? bus.jump_addr : bus.instr_pc + bus.branch_off;
        valid_d = 1'b0;
      end else begin
        instr_d = bus.rom_instr;
        ipc_d   = pc;
        valid_d = 1'b1;
        pc_d    = pc + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pc              <= '0;
      bus.instr       <= '0;
      bus.instr_pc    <= '0;
      bus.instr_valid <= 1'b0;
    end else begin
      pc              <= pc_d;
      bus.instr       <= instr_d;
      bus.instr_pc    <= ipc_d;
      bus.instr_valid <= valid_d;
    end
`ifdef RETIRE_COUNT_EN
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n)
      retired_count <= '0;
    else if (state != RUN && start)
      retired_count <= '0;
    else if (state == RUN && bus.instr_valid && !bus.stall && retired_count != 16'hFFFF)
      retired_count <= retired_count + 16'd1;
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: randomized + directed scoreboard bench for fetch_sequencer against a program-level model.
module tb_fetch_sequencer;
  localparam logic [8:0] HALT = 9'b0111_00_010;
  typedef struct {
    int         mode;
    logic [7:0] pc;
    logic [7:0] ipc;
    logic [8:0] instr;
    logic       valid;
    int         cnt;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic running, halted;
`ifdef RETIRE_COUNT_EN
  logic [15:0] retired_count;
`endif
  logic [8:0] rom [256];
  exp_t m;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(9)) bus();
  fetch_sequencer dut (
    .clk(clk), .reset_n(reset_n), .start(start), .bus(bus),
    .running(running), .halted(halted)
`ifdef RETIRE_COUNT_EN
    , .retired_count(retired_count)
`endif
  );
  assign bus.rom_instr = rom[bus.rom_addr];
  always #5 clk = ~clk;
  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  // Program-level model: mode 0 idle, 1 run, 2 halted; pc is the next fetch address.
  function automatic void step(input logic s, input logic st, input logic br, input logic [7:0] off,
                               input logic jp, input logic [7:0] ja);
    if (m.mode != 1) begin
      m.valid = 1'b0;
      if (s) begin
        m.mode = 1;
        m.pc   = 8'h00;
        m.cnt  = 0;
      end
    end else if (!st) begin
      if (m.valid) m.cnt = (m.cnt == 65535) ? 65535 : m.cnt + 1;
      if (m.valid && m.instr == HALT) begin
        m.mode  = 2;
        m.valid = 1'b0;
        m.pc    = m.ipc;
      end else if (m.valid && jp) begin
        m.pc    = ja;
        m.valid = 1'b0;
      end else if (m.valid && br) begin
        m.pc    = 8'((int'(m.ipc) + int'($signed(off)) + 256) % 256);
        m.valid = 1'b0;
      end else begin
        m.ipc   = m.pc;
        m.instr = rom[m.pc];
        m.valid = 1'b1;
        m.pc    = 8'((int'(m.pc) + 1) % 256);
      end
    end
  endfunction
  task automatic cyc(input logic s, input logic st, input logic br, input logic [7:0] off,
                     input logic jp, input logic [7:0] ja);
    @(negedge clk);
    start = s;
    bus.stall = st;
    bus.branch_taken = br;
    bus.branch_off = off;
    bus.jump = jp;
    bus.jump_addr = ja;
    step(s, st, br, off, jp, ja);
    q.push_back(m);
  endtask
  task automatic run_to(input logic [7:0] a);
    int n = 0;
    while (!(m.mode == 1 && m.valid && m.ipc == a) && n < 600) begin
      cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      n++;
    end
    chk("run_to_reached", int'(n < 600), 1);
  endtask
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    m = '{default: 0};
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_instr", bus.instr, 0);
    chk("rst_instr_pc", bus.instr_pc, 0);
    chk("rst_instr_valid", bus.instr_valid, 0);
    chk("rst_running", running, 0);
    chk("rst_halted", halted, 0);
`ifdef RETIRE_COUNT_EN
    chk("rst_retired_count", retired_count, 0);
`endif
    @(negedge clk);
    start = 1'b0;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.jump = 1'b0;
    reset_n = 1'b1;
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("rom_addr", bus.rom_addr, e.pc);
      chk("instr_valid", bus.instr_valid, e.valid);
      chk("instr", bus.instr, e.instr);
      chk("instr_pc", bus.instr_pc, e.ipc);
      chk("running", running, int'(e.mode == 1));
      chk("halted", halted, int'(e.mode == 2));
`ifdef RETIRE_COUNT_EN
      chk("retired_count", retired_count, e.cnt);
`endif
    end
  end
  initial begin
    for (int i = 0; i < 256; i++) begin
      rom[i] = 9'($urandom);
      if (rom[i] == HALT) rom[i] = ~HALT;
    end
    rom[19] = HALT;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_off = 8'h00;
    bus.jump = 1'b0;
    bus.jump_addr = 8'h00;
    m = '{default: 0};
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    run_to(8'd10);
    cyc(1'b0, 1'b0, 1'b1, 8'h02, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    run_to(8'd15);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'd8);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    run_to(8'd9);
    cyc(1'b0, 1'b0, 1'b1, 8'h05, 1'b1, 8'd3);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    run_to(8'd1);
    cyc(1'b0, 1'b0, 1'b1, 8'hFE, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    run_to(8'd5);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    run_to(8'd19);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 600; i++)
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
          8'($urandom), $urandom_range(0, 9) == 0, 8'($urandom));
    run_to(8'd3);
    do_reset();
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
